// File: rtl/ctrl_decode_seq.sv
// ctrl_decode_seq: decodes the ID-stage instruction into the EX control
// bundle, holds it in the ID/EX control register (stall / flush / bubble),
// latches and prioritises masked interrupt lines, and tracks a multi-cycle
// MULT/DIV unit whose busy window stalls dependent instructions in ID.
module ctrl_decode_seq #(
  parameter  int NUM_IRQ     = 4,
  parameter  int MDU_LATENCY = 32,
  localparam int IRQ_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int CNT_W       = $clog2(MDU_LATENCY + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic [1:0]         RegimmFunct,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               kernel_mode,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               id_stall,
  output logic               mdu_busy,
  output logic               ex_valid,
  output logic               ex_RegWrite,
  output logic               ex_MemRead,
  output logic               ex_MemWrite,
  output logic               ex_ALUSrc1,
  output logic               ex_ALUSrc2,
  output logic               ex_ExtOp,
  output logic               ex_LuOp,
  output logic               ex_Exception,
  output logic               ex_Interrupt,
  output logic [1:0]         ex_PCSrc,
  output logic [1:0]         ex_RegDst,
  output logic [1:0]         ex_MemtoReg,
  output logic [2:0]         ex_Branch,
  output logic [3:0]         ex_ALUOp,
  output logic [IRQ_W-1:0]   ex_irq_cause
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src1;
    logic             alu_src2;
    logic             ext_op;
    logic             lu_op;
    logic             exception;
    logic             interrupt;
    logic [1:0]       pc_src;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [2:0]       branch;
    logic [3:0]       alu_op;
    logic [IRQ_W-1:0] irq_cause;
  } ctrl_t;

  // Lowest-numbered pending line wins.
  function automatic logic [IRQ_W-1:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
    logic [IRQ_W-1:0] idx;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IRQ_W'(i);
      end
    end
    return idx;
  endfunction

  // Trap entry (interrupt or illegal opcode): write the link register,
  // suppress memory access and any control transfer.
  function automatic ctrl_t apply_trap(input ctrl_t c);
    ctrl_t r;
    r            = c;
    r.reg_write  = 1'b1;
    r.reg_dst    = 2'b11;
    r.mem_to_reg = 2'b10;
    r.mem_read   = 1'b0;
    r.mem_write  = 1'b0;
    r.branch     = 3'b000;
    r.pc_src     = 2'b00;
    return r;
  endfunction

  ctrl_t              ex_q, ex_d, dec_s;
  logic               illegal_s;
  logic               flush_pend_q, flush_pend_d;
  logic [NUM_IRQ-1:0] irq_pend_q, irq_pend_d, ack_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_rtype_s, mdu_op_s, mdu_dep_s, take_irq_s, mdu_load_s;
  logic [IRQ_W-1:0]   irq_idx_s;

  assign is_rtype_s = (OpCode == 6'h00);
  assign mdu_op_s   = is_rtype_s && (Funct[5:2] == 4'b0110);
  assign mdu_dep_s  = is_rtype_s && ((Funct == 6'h10) || (Funct == 6'h12) || (Funct[5:2] == 4'b0110));
  assign take_irq_s = (irq_pend_q != '0) && !kernel_mode;
  assign irq_idx_s  = lowest_idx(irq_pend_q);
  assign mdu_busy   = (cnt_q != '0);
  assign id_stall   = ex_stall | (mdu_busy & mdu_dep_s);

  // Combinational instruction decode; anything not listed decodes to zero.
  always_comb begin
    dec_s              = '0;
    dec_s.reg_write    = 1'b1;
    dec_s.ext_op       = 1'b1;
    dec_s.alu_op[3]    = OpCode[0];
    illegal_s          = 1'b0;
    case (OpCode)
      6'h00: begin
        dec_s.reg_dst     = 2'b01;
        dec_s.alu_op[2:0] = 3'b010;
        case (Funct)
          6'h00, 6'h02, 6'h03: dec_s.alu_src1 = 1'b1;
          6'h08: begin
            dec_s.pc_src    = 2'b10;
            dec_s.reg_write = 1'b0;
          end
          6'h09: begin
            dec_s.pc_src     = 2'b10;
            dec_s.mem_to_reg = 2'b10;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: dec_s.reg_write = 1'b0;
          default: dec_s.alu_src1 = 1'b0;
        endcase
      end
      6'h01: begin
        dec_s.branch     = RegimmFunct[0] ? 3'b110 : 3'b101;
        dec_s.reg_write  = RegimmFunct[1];
        dec_s.reg_dst    = 2'b10;
        dec_s.mem_to_reg = 2'b10;
      end
      6'h02: begin
        dec_s.pc_src    = 2'b01;
        dec_s.reg_write = 1'b0;
      end
      6'h03: begin
        dec_s.pc_src     = 2'b01;
        dec_s.reg_dst    = 2'b10;
        dec_s.mem_to_reg = 2'b10;
      end
      6'h04: begin
        dec_s.branch      = 3'b001;
        dec_s.reg_write   = 1'b0;
        dec_s.alu_op[2:0] = 3'b001;
      end
      6'h05: begin
        dec_s.branch    = 3'b010;
        dec_s.reg_write = 1'b0;
      end
      6'h06: begin
        dec_s.branch    = 3'b011;
        dec_s.reg_write = 1'b0;
      end
      6'h07: begin
        dec_s.branch    = 3'b100;
        dec_s.reg_write = 1'b0;
      end
      6'h08, 6'h09: dec_s.alu_src2 = 1'b1;
      6'h0a, 6'h0b: begin
        dec_s.alu_src2    = 1'b1;
        dec_s.alu_op[2:0] = 3'b101;
      end
      6'h0c: begin
        dec_s.alu_src2    = 1'b1;
        dec_s.ext_op      = 1'b0;
        dec_s.alu_op[2:0] = 3'b100;
      end
      6'h0d: begin
        dec_s.alu_src2    = 1'b1;
        dec_s.ext_op      = 1'b0;
        dec_s.alu_op[2:0] = 3'b110;
      end
      6'h0f: begin
        dec_s.alu_src2 = 1'b1;
        dec_s.lu_op    = 1'b1;
      end
      6'h23: begin
        dec_s.alu_src2   = 1'b1;
        dec_s.mem_read   = 1'b1;
        dec_s.mem_to_reg = 2'b01;
      end
      6'h2b: begin
        dec_s.alu_src2  = 1'b1;
        dec_s.mem_write = 1'b1;
        dec_s.reg_write = 1'b0;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // ID/EX next state: stall holds, flush (now or remembered) and ID stalls
  // insert bubbles, otherwise load the decode with trap overrides.
  always_comb begin
    ex_d         = ex_q;
    flush_pend_d = flush_pend_q;
    ack_s        = '0;
    mdu_load_s   = 1'b0;
    if (ex_stall) begin
      flush_pend_d = flush_pend_q | flush;
    end else if (flush || flush_pend_q) begin
      ex_d         = '0;
      flush_pend_d = 1'b0;
    end else if (id_stall || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d       = dec_s;
      ex_d.valid = 1'b1;
      if (take_irq_s) begin
        ex_d           = apply_trap(ex_d);
        ex_d.interrupt = 1'b1;
        ex_d.exception = 1'b0;
        ex_d.irq_cause = irq_idx_s;
        ack_s          = NUM_IRQ'(1'b1) << irq_idx_s;
      end else if (illegal_s) begin
        ex_d           = apply_trap(ex_d);
        ex_d.exception = 1'b1;
      end else begin
        mdu_load_s = mdu_op_s;
      end
    end
  end

  // Sticky pending interrupts; a fresh request beats a same-edge acknowledge.
  always_comb begin
    irq_pend_d = (irq_pend_q & ~ack_s) | (irq & irq_mask);
  end

  // MDU busy counter: reload on a MULT/DIV load, else count down to zero.
  always_comb begin
    if (mdu_load_s) begin
      cnt_d = CNT_W'(MDU_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q         <= '0;
      flush_pend_q <= 1'b0;
      irq_pend_q   <= '0;
      cnt_q        <= '0;
    end else begin
      ex_q         <= ex_d;
      flush_pend_q <= flush_pend_d;
      irq_pend_q   <= irq_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_RegWrite  = ex_q.reg_write;
  assign ex_MemRead   = ex_q.mem_read;
  assign ex_MemWrite  = ex_q.mem_write;
  assign ex_ALUSrc1   = ex_q.alu_src1;
  assign ex_ALUSrc2   = ex_q.alu_src2;
  assign ex_ExtOp     = ex_q.ext_op;
  assign ex_LuOp      = ex_q.lu_op;
  assign ex_Exception = ex_q.exception;
  assign ex_Interrupt = ex_q.interrupt;
  assign ex_PCSrc     = ex_q.pc_src;
  assign ex_RegDst    = ex_q.reg_dst;
  assign ex_MemtoReg  = ex_q.mem_to_reg;
  assign ex_Branch    = ex_q.branch;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_irq_cause = ex_q.irq_cause;

endmodule

// File: tb/tb_ctrl_decode_seq.sv
// Testbench for ctrl_decode_seq: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the decode/control stage.
module tb_ctrl_decode_seq;
  localparam int NIRQ = 4;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, kernel_mode, ex_stall, flush;
  logic [5:0]      OpCode, Funct;
  logic [1:0]      RegimmFunct;
  logic [NIRQ-1:0] irq, irq_mask;
  logic            id_stall, mdu_busy;
  logic            ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2;
  logic            ex_ExtOp, ex_LuOp, ex_Exception, ex_Interrupt;
  logic [1:0]      ex_PCSrc, ex_RegDst, ex_MemtoReg;
  logic [2:0]      ex_Branch;
  logic [3:0]      ex_ALUOp;
  logic [1:0]      ex_irq_cause;

  ctrl_decode_seq #(.NUM_IRQ(NIRQ), .MDU_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .OpCode(OpCode), .Funct(Funct),
    .RegimmFunct(RegimmFunct), .irq(irq), .irq_mask(irq_mask), .kernel_mode(kernel_mode),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall), .mdu_busy(mdu_busy),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2),
    .ex_ExtOp(ex_ExtOp), .ex_LuOp(ex_LuOp), .ex_Exception(ex_Exception),
    .ex_Interrupt(ex_Interrupt), .ex_PCSrc(ex_PCSrc), .ex_RegDst(ex_RegDst),
    .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch), .ex_ALUOp(ex_ALUOp),
    .ex_irq_cause(ex_irq_cause)
  );

  typedef struct packed {
    logic       valid, rw, mr, mw, as1, as2, ext, lu, exc, intr;
    logic [1:0] pcsrc, regdst, m2r;
    logic [2:0] br;
    logic [3:0] aluop;
    logic [1:0] cause;
  } bundle_t;

  bundle_t dut_ex;
  assign dut_ex = {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2,
                   ex_ExtOp, ex_LuOp, ex_Exception, ex_Interrupt, ex_PCSrc, ex_RegDst,
                   ex_MemtoReg, ex_Branch, ex_ALUOp, ex_irq_cause};

  // Reference model state
  bundle_t         m_ex;
  int              m_busy;
  logic            m_fp;
  logic [NIRQ-1:0] m_pend;
  logic            exp_stall, exp_busy, obs_stall, obs_busy;
  int              n_cmp, n_err;

  // Instruction-level decode straight from the opcode/funct tables.
  function automatic bundle_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] rf);
    bundle_t b;
    logic    rt;
    rt      = (op == 6'h00);
    b       = '0;
    b.valid = 1'b1;
    b.rw    = !((op inside {6'h2b, 6'h02, [6'h04:6'h07]}) || (rt && (fn == 6'h08)) ||
                ((op == 6'h01) && !rf[1]) || (rt && (fn inside {[6'h18:6'h1b]})));
    b.mr    = (op == 6'h23);
    b.mw    = (op == 6'h2b);
    b.as1   = rt && (fn inside {6'h00, 6'h02, 6'h03});
    b.as2   = (op inside {6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b, 6'h0d});
    b.ext   = !(op inside {6'h0c, 6'h0d});
    b.lu    = (op == 6'h0f);
    b.pcsrc = (op inside {6'h02, 6'h03}) ? 2'b01 : (rt && (fn inside {6'h08, 6'h09})) ? 2'b10 : 2'b00;
    b.regdst = (op inside {6'h03, 6'h01}) ? 2'b10 : rt ? 2'b01 : 2'b00;
    b.m2r   = (op == 6'h23) ? 2'b01 :
              ((op inside {6'h03, 6'h01}) || (rt && (fn == 6'h09))) ? 2'b10 : 2'b00;
    case (op)
      6'h04:   b.br = 3'd1;
      6'h05:   b.br = 3'd2;
      6'h06:   b.br = 3'd3;
      6'h07:   b.br = 3'd4;
      6'h01:   b.br = rf[0] ? 3'd6 : 3'd5;
      default: b.br = 3'd0;
    endcase
    b.aluop[2:0] = rt ? 3'b010 : (op == 6'h04) ? 3'b001 : (op == 6'h0c) ? 3'b100 :
                   (op == 6'h0d) ? 3'b110 : (op inside {6'h0a, 6'h0b}) ? 3'b101 : 3'b000;
    b.aluop[3] = op[0];
    return b;
  endfunction

  function automatic bundle_t ref_trap(input bundle_t c);
    bundle_t r;
    r = c;
    r.rw = 1'b1; r.regdst = 2'b11; r.m2r = 2'b10;
    r.mr = 1'b0; r.mw = 1'b0; r.br = 3'd0; r.pcsrc = 2'b00;
    return r;
  endfunction

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] rf, input logic v);
    OpCode = op; Funct = fn; RegimmFunct = rf; id_valid = v;
  endtask

  // One clock: sample combinational outputs, advance, update the model.
  task automatic tick();
    bundle_t         nx;
    logic            rt, dep, mdu, illegal, load;
    logic [NIRQ-1:0] ack;
    int              lo;
    #2;
    obs_stall = id_stall;
    obs_busy  = mdu_busy;
    rt        = (OpCode == 6'h00);
    dep       = rt && (Funct inside {6'h10, 6'h12, [6'h18:6'h1b]});
    mdu       = rt && (Funct inside {[6'h18:6'h1b]});
    illegal   = !(OpCode inside {[6'h00:6'h0d], 6'h0f, 6'h23, 6'h2b});
    exp_busy  = (m_busy != 0);
    exp_stall = ex_stall || (exp_busy && dep);
    lo = -1;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (m_pend[i]) lo = i;
    end
    nx   = m_ex;
    ack  = '0;
    load = 1'b0;
    @(posedge clk);
    if (reset) begin
      m_ex = '0; m_busy = 0; m_fp = 1'b0; m_pend = '0;
    end else begin
      if (ex_stall) begin
        m_fp = m_fp | flush;
      end else if (flush || m_fp) begin
        nx = '0; m_fp = 1'b0;
      end else if (exp_stall || !id_valid) begin
        nx = '0;
      end else begin
        nx = ref_decode(OpCode, Funct, RegimmFunct);
        if (lo >= 0 && !kernel_mode) begin
          nx = ref_trap(nx); nx.intr = 1'b1; nx.cause = 2'(lo); ack[lo] = 1'b1;
        end else if (illegal) begin
          nx = ref_trap(nx); nx.exc = 1'b1;
        end else begin
          load = mdu;
        end
      end
      m_ex = nx;
      if (load) m_busy = LAT;
      else if (m_busy > 0) m_busy--;
      m_pend = (m_pend & ~ack) | (irq & irq_mask);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; kernel_mode = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    irq = '0; irq_mask = '0;
    set_instr(6'h23, 6'h00, 2'b00, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (dut_ex !== '0) begin n_err++; $display("FAIL reset_bundle: got %h want 0", dut_ex); end
      n_cmp++;
      if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", mdu_busy); end
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({ex_valid, ex_MemRead, ex_MemtoReg, ex_ALUSrc2} !== 5'b11011) begin
      n_err++; $display("FAIL reset_first_lw: got %b want 11011", {ex_valid, ex_MemRead, ex_MemtoReg, ex_ALUSrc2});
    end
    n_cmp++;
    if (dut_ex !== m_ex) begin n_err++; $display("FAIL reset_first_model: got %h want %h", dut_ex, m_ex); end
  endtask

  task automatic test_illegal();
    kernel_mode = 1'b1;
    set_instr(6'h3f, 6'h2a, 2'b11, 1'b1);
    tick();
    n_cmp++;
    if ({ex_Exception, ex_RegDst, ex_MemtoReg, ex_MemWrite, ex_Interrupt} !== 7'b1111000) begin
      n_err++; $display("FAIL illegal_trap: got %b want 1111000",
                        {ex_Exception, ex_RegDst, ex_MemtoReg, ex_MemWrite, ex_Interrupt});
    end
    n_cmp++;
    if ($isunknown({dut_ex, id_stall, mdu_busy})) begin
      n_err++; $display("FAIL illegal_noX: got %h want no X", dut_ex);
    end
    n_cmp++;
    if (dut_ex !== m_ex) begin n_err++; $display("FAIL illegal_model: got %h want %h", dut_ex, m_ex); end
  endtask

  task automatic test_irq_priority();
    kernel_mode = 1'b0; irq_mask = 4'b1111; irq = 4'b1010;
    set_instr(6'h00, 6'h20, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({ex_valid, ex_Interrupt} !== 2'b10) begin
      n_err++; $display("FAIL irq_latch_edge: got %b want 10", {ex_valid, ex_Interrupt});
    end
    irq = 4'b0000;
    tick();
    n_cmp++;
    if ({ex_Interrupt, ex_Exception, ex_irq_cause, ex_RegDst, ex_RegWrite} !== 7'b1001111) begin
      n_err++; $display("FAIL irq_cause1: got %b want 1001111",
                        {ex_Interrupt, ex_Exception, ex_irq_cause, ex_RegDst, ex_RegWrite});
    end
    tick();
    n_cmp++;
    if ({ex_Interrupt, ex_irq_cause} !== 3'b111) begin
      n_err++; $display("FAIL irq_cause3: got %b want 111", {ex_Interrupt, ex_irq_cause});
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_Interrupt} !== 2'b10) begin
      n_err++; $display("FAIL irq_drained: got %b want 10", {ex_valid, ex_Interrupt});
    end
    n_cmp++;
    if (dut_ex !== m_ex) begin n_err++; $display("FAIL irq_model: got %h want %h", dut_ex, m_ex); end
    irq_mask = '0;
  endtask

  task automatic test_mdu();
    kernel_mode = 1'b1;
    set_instr(6'h00, 6'h18, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({ex_valid, ex_RegWrite, mdu_busy} !== 3'b101) begin
      n_err++; $display("FAIL mdu_mult_load: got %b want 101", {ex_valid, ex_RegWrite, mdu_busy});
    end
    set_instr(6'h00, 6'h12, 2'b00, 1'b1);
    for (int k = 0; k < LAT; k++) begin
      tick();
      n_cmp++;
      if ({obs_stall, ex_valid} !== 2'b10) begin
        n_err++; $display("FAIL mdu_mflo_stall%0d: got %b want 10", k, {obs_stall, ex_valid});
      end
    end
    tick();
    n_cmp++;
    if ({obs_stall, ex_valid, ex_RegWrite, ex_RegDst} !== 5'b01101) begin
      n_err++; $display("FAIL mdu_mflo_load: got %b want 01101", {obs_stall, ex_valid, ex_RegWrite, ex_RegDst});
    end
    set_instr(6'h00, 6'h1a, 2'b00, 1'b1);
    tick();
    set_instr(6'h00, 6'h20, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if ({obs_busy, obs_stall, ex_valid} !== 3'b101) begin
      n_err++; $display("FAIL mdu_add_not_stalled: got %b want 101", {obs_busy, obs_stall, ex_valid});
    end
    id_valid = 1'b0;
    repeat (LAT) tick();
    n_cmp++;
    if (mdu_busy !== 1'b0) begin n_err++; $display("FAIL mdu_drain: got %b want 0", mdu_busy); end
  endtask

  task automatic test_stall_flush();
    bundle_t held;
    kernel_mode = 1'b1;
    set_instr(6'h0d, 6'h00, 2'b00, 1'b1);
    tick();
    held = m_ex;
    set_instr(6'h23, 6'h00, 2'b00, 1'b1);
    ex_stall = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (dut_ex !== held) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", k, dut_ex, held); end
      if (k < 2) tick();
    end
    ex_stall = 1'b0;
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_pend_bubble: got %b want 0", ex_valid); end
    tick();
    n_cmp++;
    if ({ex_valid, ex_MemRead} !== 2'b11) begin
      n_err++; $display("FAIL flush_pend_cleared: got %b want 11", {ex_valid, ex_MemRead});
    end
  endtask

  task automatic test_mask();
    kernel_mode = 1'b0; irq = 4'b0001; irq_mask = 4'b0000;
    set_instr(6'h00, 6'h20, 2'b00, 1'b1);
    repeat (3) begin
      tick();
      n_cmp++;
      if (ex_Interrupt !== 1'b0) begin n_err++; $display("FAIL mask_blocked: got %b want 0", ex_Interrupt); end
    end
    irq_mask = 4'b0001;
    tick();
    irq = 4'b0000;
    tick();
    n_cmp++;
    if ({ex_Interrupt, ex_irq_cause} !== 3'b100) begin
      n_err++; $display("FAIL mask_taken: got %b want 100", {ex_Interrupt, ex_irq_cause});
    end
    tick();
    n_cmp++;
    if (ex_Interrupt !== 1'b0) begin n_err++; $display("FAIL mask_acked: got %b want 0", ex_Interrupt); end
    irq_mask = '0;
  endtask

  task automatic test_random();
    logic [5:0] ops [22];
    logic [5:0] fns [14];
    ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
            6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h11};
    fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b,
            6'h20, 6'h21, 6'h2a};
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      kernel_mode = ($urandom_range(0, 2) == 0);
      ex_stall    = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      irq         = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      irq_mask    = 4'($urandom);
      set_instr(ops[$urandom_range(0, 21)], fns[$urandom_range(0, 13)], 2'($urandom),
                ($urandom_range(0, 7) != 0));
      tick();
      n_cmp++;
      if (obs_stall !== exp_stall) begin
        n_err++; $display("FAIL rand_id_stall@%0d: got %b want %b", n, obs_stall, exp_stall);
      end
      n_cmp++;
      if (obs_busy !== exp_busy) begin
        n_err++; $display("FAIL rand_mdu_busy@%0d: got %b want %b", n, obs_busy, exp_busy);
      end
      n_cmp++;
      if (dut_ex !== m_ex) begin
        n_err++; $display("FAIL rand_bundle@%0d: got %h want %h", n, dut_ex, m_ex);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    m_ex = '0; m_busy = 0; m_fp = 1'b0; m_pend = '0;
    reset = 1'b1; id_valid = 1'b0; kernel_mode = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    OpCode = 6'h00; Funct = 6'h00; RegimmFunct = 2'b00; irq = '0; irq_mask = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_illegal();
    test_irq_priority();
    test_mdu();
    test_stall_flush();
    test_mask();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_seq.md
Name: ctrl_decode_seq

Overview:
Registered decode/control stage for the 5-stage MIPS pipeline. It decodes the ID-stage instruction into the EX control bundle and holds that bundle in an ID/EX control register with stall, flush and bubble handling. It latches and prioritises multiple masked interrupt lines, and sequences multi-cycle MULT/DIV ops with a busy counter that stalls dependent instructions. It generalises the combinational decoder: parametrised IRQ count and MDU latency, and no X outputs.

Parameters:
NUM_IRQ, 4, number of external interrupt lines (1..16)
MDU_LATENCY, 32, cycles MDU stays busy after a MULT/MULTU/DIV/DIVU enters EX (>=1)
IRQ_W (localparam), max(1,clog2(NUM_IRQ)), cause-index width
CNT_W (localparam), clog2(MDU_LATENCY+1), counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
OpCode  in  6  instr[31:26]
Funct  in  6  instr[5:0]
RegimmFunct  in  2  {instr[20],instr[16]}
irq  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  1 = line enabled
kernel_mode  in  1  1 = interrupts not taken
ex_stall  in  1  downstream hazard; hold ID/EX
flush  in  1  taken branch/jump in EX; kill ID instruction
id_stall  out  1  hold PC and IF/ID
mdu_busy  out  1  MDU counter nonzero
ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2, ex_ExtOp, ex_LuOp, ex_Exception, ex_Interrupt  out  1 each  registered controls
ex_PCSrc, ex_RegDst, ex_MemtoReg  out  2 each  registered controls
ex_Branch  out  3  registered branch type
ex_ALUOp  out  4  registered ALU op
ex_irq_cause  out  IRQ_W  taken interrupt index

Behaviour:
- Decode (combinational, internal):
  - PCSrc: 01 for J/JAL (0x02/0x03); 10 for R-type Funct 0x08/0x09; else 00.
  - Branch: BEQ 001, BNE 010, BLEZ 011, BGTZ 100. REGIMM (0x01) gives 101 if RegimmFunct[0]=0, else 110. All others 000.
  - RegWrite = 0 for SW, BEQ/BNE/BLEZ/BGTZ, J, JR, REGIMM with RegimmFunct[1]=0, and Funct 0x18-0x1B. All others 1.
  - RegDst: 10 for JAL/REGIMM; 00 for I-type ALU/LW/LUI; 01 for R-type; 00 otherwise.
  - MemRead = LW (0x23). MemWrite = SW (0x2b).
  - MemtoReg: 01 for LW; 10 for JAL, REGIMM, JALR; else 00.
  - ALUSrc1 = 1 for SLL/SRL/SRA. ALUSrc2 = 1 for LW/SW/LUI/ADDI/ADDIU/ANDI/SLTI/SLTIU/ORI.
  - ExtOp = 0 for ANDI/ORI, else 1. LuOp = 1 for LUI.
  - ALUOp[2:0]: R-type 010, BEQ 001, ANDI 100, ORI 110, SLTI/SLTIU 101, else 000. ALUOp[3] = OpCode[0].
  - Illegal = OpCode not in {0x00..0x0d, 0x0f, 0x23, 0x2b}.
  - Every don't-care decodes to 0.
- Bubble: all ex_* = 0.
- Reset: all ex_* = 0, irq_pend = 0, MDU counter = 0, flush_pend = 0.
- ID/EX update priority at posedge:
  1. reset
  2. ex_stall: hold all ex_*. If flush=1, set flush_pend.
  3. flush or flush_pend: load bubble, clear flush_pend
  4. id_stall, or id_valid=0: load bubble
  5. else load decode with ex_valid=1
- irq_pend[i] is set when irq[i]&irq_mask[i]. It is sticky and cleared only on acknowledge or reset.
- Interrupt taken on a case-5 load when irq_pend!=0 and kernel_mode=0:
  - ex_Interrupt=1, ex_Exception=0, ex_irq_cause = lowest set index; that pend bit is cleared on the same edge.
  - Forced controls: RegWrite=1, RegDst=11, MemtoReg=10, MemRead=MemWrite=0, Branch=000, PCSrc=00.
  - A new irq on the same bit in the same cycle wins: the bit stays set.
- Illegal opcode with no interrupt taken: ex_Exception=1, with the same forced controls. Taken in either mode.
- MDU: loading Funct 0x18-0x1B (R-type, valid, not interrupted) sets counter = MDU_LATENCY.
  - Otherwise a nonzero counter decrements every cycle, independent of ex_stall. mdu_busy = (counter!=0).
  - id_stall = ex_stall | (mdu_busy & ID is MFHI 0x10 / MFLO 0x12 / MULT-DIV family).
  - Non-MDU instructions are not stalled.
- Reset mid-MDU or mid-stall clears everything next edge. Decoding restarts at the first non-reset cycle.

Test Plan:
- Reset held 2 cycles with LW in ID -> all ex_*=0. First edge after release: ex_valid=1, ex_MemRead=1, ex_MemtoReg=01, ex_ALUSrc2=1.
- OpCode=0x3f, kernel_mode=1 -> ex_Exception=1, RegDst=11, MemtoReg=10, MemWrite=0; no X on any output.
- irq=4'b1010, mask=4'b1111, kernel_mode=0, ADD in ID -> ex_Interrupt=1, cause=1. Next instruction -> cause=3. irq_pend returns to 0.
- MULT enters EX, MDU_LATENCY=4, MFLO in ID -> id_stall=1 for exactly 4 cycles with bubbles into EX. MFLO loads on the 5th edge. An ADD in ID during busy is not stalled.
- ex_stall=1 for 3 cycles with flush pulsed in cycle 1 -> ex_* held. First unstalled edge loads a bubble; flush_pend then clears.
- irq asserted with mask bit 0 -> never taken. Mask set later -> taken on the next valid unstalled load.
